// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared types and constants for the LC-3b MEM stage: the
//               data-memory controller state encoding, the decoded memory
//               request bundle, the default response-watchdog limit and a
//               lane-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    // Controller phases: IDLE serves direct accesses and the pointer fetch of
    // an indirect access; IND serves the second (data) phase at the pointer.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        IND  = 1'b1
    } mem_ctrl_state_t;

    // Decoded memory request from the EX/MEM latch.
    typedef struct packed {
        logic read;
        logic write;
        logic byte_acc;
        logic ind;
    } lc3b_mem_req_t;

    // Default number of cycles the dcache may stay silent before the
    // controller gives up on an access.
    localparam int MEM_MAX_WAIT = 64;

    // Width of the byte-lane index; at least one bit so that single-lane
    // configurations still have a legal vector.
    function automatic int lane_bits(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_lane
// Description : Combinational byte-lane formatter between the MEM controller
//               and the dcache. Selects the addressed byte of read data and
//               sign-extends it, replicates store bytes across all lanes and
//               produces write lane enables.
// Ports       : lane_i     - byte lane index (address LSBs)
//               byte_i     - byte access when high, full word otherwise
//               wdata_i    - store data from the pipeline
//               rdata_i    - raw dcache read data
//               wdata_o    - store data presented to the dcache
//               byte_en_o  - write lane enables
//               rdata_o    - formatted load data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_lane
    import lc3b_types::*;
#(
    parameter int DATA_W = 16,
    parameter int LSB_W  = 1
) (
    input  logic [LSB_W-1:0]    lane_i,
    input  logic                byte_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] byte_en_o,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int LANES = DATA_W / 8;

    logic [7:0]       w_sel_byte;
    logic [LANES-1:0] w_onehot;

    // Lane 0 is the fallback so a single-lane build always selects its only byte.
    always_comb begin
        w_sel_byte = rdata_i[7:0];
        w_onehot   = '0;
        for (int k = 0; k < LANES; k++) begin
            if ((LANES == 1) || (LSB_W'(k) == lane_i)) begin
                w_sel_byte  = rdata_i[k*8 +: 8];
                w_onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        wdata_o   = wdata_i;
        byte_en_o = '1;
        rdata_o   = rdata_i;
        if (byte_i) begin
            wdata_o   = {LANES{wdata_i[7:0]}};
            byte_en_o = w_onehot;
            rdata_o   = DATA_W'($signed(w_sel_byte));
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Pipelined MEM-stage data-memory access controller. Drives
//               dcache requests for word/byte loads and stores, sequences
//               two-phase indirect accesses, generates the pipeline stall and
//               aborts accesses whose dcache response never arrives.
// Config      : MEM_INDIRECT_EN - when defined, req_ind selects a pointer
//               fetch followed by the data access at the fetched pointer.
//               When undefined, req_ind is ignored and no IND state exists.
// Ports       : clk, rst_n              - clock, synchronous active-low reset
//               valid_in, req_*         - instruction in EX/MEM latch
//               addr_in, wdata_in       - effective address, store data
//               mem_rdata, dcache_resp  - dcache read data / completion
//               mem_address, mem_read, mem_write, mem_byte_en, mem_wdata
//                                       - dcache request
//               data_out, valid_out     - MEM/WB result and retire strobe
//               mem_stall, mem_err      - pipeline hold, watchdog abort pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import lc3b_types::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = MEM_MAX_WAIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic                req_read,
    input  logic                req_write,
    input  logic                req_byte,
    input  logic                req_ind,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   wdata_in,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                dcache_resp,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byte_en,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   data_out,
    output logic                valid_out,
    output logic                mem_stall,
    output logic                mem_err
);

    localparam int LANES = DATA_W / 8;
    localparam int LSB_W = lane_bits(LANES);
    localparam int CNT_W = $clog2(MAX_WAIT) + 1;

    lc3b_mem_req_t     w_req;
    logic              w_op;
    logic              w_ptr_phase;
    logic              w_final;
    logic              w_abort;
    logic              w_stall;
    logic              w_done;
    logic              w_byte_eff;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_wdata_fmt;
    logic [DATA_W-1:0] w_rdata_fmt;
    logic [LANES-1:0]  w_byte_en;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0]  wait_cnt_d;

    // A simultaneous read+write request is serviced as a store.
    assign w_req = '{read:     req_read & ~req_write,
                     write:    req_write,
                     byte_acc: req_byte,
                     ind:      req_ind};

    assign w_op = valid_in & (req_read | req_write);

`ifdef MEM_INDIRECT_EN
    mem_ctrl_state_t   state_q;
    mem_ctrl_state_t   state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (w_op && w_ptr_phase && dcache_resp) begin
                    state_d = IND;
                    ptr_d   = ADDR_W'(mem_rdata);
                end
            end
            IND: begin
                // A flushed instruction (valid_in dropped) also ends the access.
                if (!w_op || dcache_resp || w_abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The pointer fetch is the IDLE phase of an indirect access.
    assign w_ptr_phase = (state_q == IDLE) & w_req.ind;
    assign w_acc_addr  = (state_q == IND) ? ptr_q : addr_in;
`else
    logic w_unused_ind;

    assign w_unused_ind = w_req.ind;
    assign w_ptr_phase  = 1'b0;
    assign w_acc_addr   = addr_in;
`endif

    assign w_final    = ~w_ptr_phase;
    assign w_byte_eff = w_req.byte_acc & ~w_ptr_phase;

    // A response on the last allowed cycle still completes the access.
    assign w_abort = w_op & ~dcache_resp & (wait_cnt_q == CNT_W'(MAX_WAIT - 1));
    assign w_done  = w_op & dcache_resp & w_final;
    assign w_stall = w_op & ~w_done & ~w_abort;

    // Watchdog counts silent stalled cycles; any response restarts it.
    assign wait_cnt_d = (w_stall && !dcache_resp) ? (wait_cnt_q + 1'b1) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Word accesses are always lane-aligned.
    generate
        if (LANES > 1) begin : g_addr_mask
            assign w_mem_addr = w_byte_eff ? w_acc_addr
                                           : {w_acc_addr[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
        end else begin : g_addr_pass
            assign w_mem_addr = w_acc_addr;
        end
    endgenerate

    mem_byte_lane #(
        .DATA_W (DATA_W),
        .LSB_W  (LSB_W)
    ) u_byte_lane (
        .lane_i    (w_acc_addr[LSB_W-1:0]),
        .byte_i    (w_byte_eff),
        .wdata_i   (wdata_in),
        .rdata_i   (mem_rdata),
        .wdata_o   (w_wdata_fmt),
        .byte_en_o (w_byte_en),
        .rdata_o   (w_rdata_fmt)
    );

    assign mem_address = w_mem_addr;
    assign mem_wdata   = w_wdata_fmt;
    assign mem_byte_en = w_byte_en;

    // Output logic; every control output is held low while in reset.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_stall = 1'b0;
        valid_out = 1'b0;
        mem_err   = 1'b0;
        data_out  = '0;
        if (rst_n) begin
            mem_read  = w_op & ~w_abort & (w_ptr_phase | w_req.read);
            mem_write = w_op & ~w_abort & ~w_ptr_phase & w_req.write;
            mem_stall = w_stall;
            valid_out = valid_in & ~w_stall & ~w_abort;
            mem_err   = w_abort;
            if (w_done && w_req.read) begin
                data_out = w_rdata_fmt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl. Directed accesses
//               push their expected retirement into a queue; a monitor pops
//               and compares whenever the controller retires or aborts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        req_read;
    logic        req_write;
    logic        req_byte;
    logic        req_ind;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic [15:0] mem_rdata;
    logic        dcache_resp;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_en;
    logic [15:0] mem_wdata;
    logic [15:0] data_out;
    logic        valid_out;
    logic        mem_stall;
    logic        mem_err;

    typedef struct {
        logic        err;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    mem_access_ctrl #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_byte    (req_byte),
        .req_ind     (req_ind),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .mem_rdata   (mem_rdata),
        .dcache_resp (dcache_resp),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_byte_en (mem_byte_en),
        .mem_wdata   (mem_wdata),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .mem_stall   (mem_stall),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        valid_in    = 1'b0;
        req_read    = 1'b0;
        req_write   = 1'b0;
        req_byte    = 1'b0;
        req_ind     = 1'b0;
        dcache_resp = 1'b0;
        addr_in     = 16'h0;
        wdata_in    = 16'h0;
        mem_rdata   = 16'h0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic by, input logic ind,
                         input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] rd_data, input logic resp);
        valid_in    = 1'b1;
        req_read    = rd;
        req_write   = wr;
        req_byte    = by;
        req_ind     = ind;
        addr_in     = a;
        wdata_in    = wd;
        mem_rdata   = rd_data;
        dcache_resp = resp;
    endtask

    // Retirement monitor
    always @(negedge clk) begin
        if (rst_n && (valid_out || mem_err)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL retire_unexpected valid_out=%0b mem_err=%0b data_out=%0h",
                         valid_out, mem_err, data_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ((mem_err !== e.err) || (valid_out !== ~e.err) || (data_out !== e.data)) begin
                    bad++;
                    $display("FAIL retire actual err=%0b valid=%0b data=%0h required err=%0b valid=%0b data=%0h",
                             mem_err, valid_out, data_out, e.err, ~e.err, e.data);
                end
            end
        end
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_in();
        rst_n = 1'b0;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        chk("rst_read", mem_read, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_err", mem_err, 0);
        next_cycle();
        idle_in();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Word load, zero-wait hit
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h1235, 16'h0, 16'hBEEF, 1'b1);
        exp_q.push_back('{err: 1'b0, data: 16'hBEEF});
        @(negedge clk);
        chk("ldr_addr", mem_address, 16'h1234);
        chk("ldr_stall", mem_stall, 0);
        chk("ldr_read", mem_read, 1);
        chk("ldr_be", mem_byte_en, 2'b11);
        next_cycle();

        // Byte load, upper lane, three-cycle wait
        issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h2001, 16'h0, 16'h80AA, 1'b0);
        exp_q.push_back('{err: 1'b0, data: 16'hFF80});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ldb_wait_stall", mem_stall, 1);
            chk("ldb_wait_data", data_out, 0);
            next_cycle();
        end
        dcache_resp = 1'b1;
        @(negedge clk);
        chk("ldb_stall_done", mem_stall, 0);
        chk("ldb_addr", mem_address, 16'h2001);
        next_cycle();

        // Byte loads, lane 0 negative and lane 1 positive
        issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h2000, 16'h0, 16'h80AA, 1'b1);
        exp_q.push_back('{err: 1'b0, data: 16'hFFAA});
        next_cycle();
        issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h2001, 16'h0, 16'h7F12, 1'b1);
        exp_q.push_back('{err: 1'b0, data: 16'h007F});
        next_cycle();

        // Byte store
        issue(1'b0, 1'b1, 1'b1, 1'b0, 16'h3000, 16'h1234, 16'h0, 1'b1);
        exp_q.push_back('{err: 1'b0, data: 16'h0000});
        @(negedge clk);
        chk("stb_wdata", mem_wdata, 16'h3434);
        chk("stb_be", mem_byte_en, 2'b01);
        chk("stb_write", mem_write, 1);
        chk("stb_read", mem_read, 0);
        next_cycle();

        // Word store to odd address
        issue(1'b0, 1'b1, 1'b0, 1'b0, 16'h3003, 16'hABCD, 16'h0, 1'b1);
        exp_q.push_back('{err: 1'b0, data: 16'h0000});
        @(negedge clk);
        chk("stw_addr", mem_address, 16'h3002);
        chk("stw_wdata", mem_wdata, 16'hABCD);
        chk("stw_be", mem_byte_en, 2'b11);
        next_cycle();

        // Read and write both set behaves as a store
        issue(1'b1, 1'b1, 1'b0, 1'b0, 16'h3010, 16'h5555, 16'h1111, 1'b1);
        exp_q.push_back('{err: 1'b0, data: 16'h0000});
        @(negedge clk);
        chk("rw_write", mem_write, 1);
        chk("rw_read", mem_read, 0);
        next_cycle();

        // Non-memory instruction passes straight through
        idle_in();
        valid_in = 1'b1;
        exp_q.push_back('{err: 1'b0, data: 16'h0000});
        @(negedge clk);
        chk("nomem_stall", mem_stall, 0);
        next_cycle();

        // Watchdog abort with MAX_WAIT=4
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h6000, 16'h0, 16'h0, 1'b0);
        exp_q.push_back('{err: 1'b1, data: 16'h0000});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wd_stall", mem_stall, 1);
            chk("wd_err_early", mem_err, 0);
            next_cycle();
        end
        @(negedge clk);
        chk("wd_err", mem_err, 1);
        chk("wd_read", mem_read, 0);
        chk("wd_stall_end", mem_stall, 0);
        next_cycle();
        idle_in();
        next_cycle();

        // Controller back in IDLE after abort
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h7000, 16'h0, 16'h1357, 1'b1);
        exp_q.push_back('{err: 1'b0, data: 16'h1357});
        @(negedge clk);
        chk("post_abort_stall", mem_stall, 0);
        next_cycle();

`ifdef MEM_INDIRECT_EN
        // Indirect load
        issue(1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h0, 16'h5000, 1'b1);
        exp_q.push_back('{err: 1'b0, data: 16'h00C3});
        @(negedge clk);
        chk("ldi_ptr_addr", mem_address, 16'h4000);
        chk("ldi_ptr_stall", mem_stall, 1);
        next_cycle();
        mem_rdata = 16'h00C3;
        @(negedge clk);
        chk("ldi_data_addr", mem_address, 16'h5000);
        chk("ldi_data_stall", mem_stall, 0);
        next_cycle();

        // Reset while in the indirect data phase
        issue(1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h0, 16'h5000, 1'b1);
        next_cycle();
        dcache_resp = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        chk("indrst_read", mem_read, 0);
        chk("indrst_stall", mem_stall, 0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("indrst_idle_addr", mem_address, 16'h4000);
        chk("indrst_idle_read", mem_read, 1);
        next_cycle();
        idle_in();
        next_cycle();
`endif

        idle_in();
        next_cycle();
        next_cycle();
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
